// File: rtl/port_grant_tracker_if.sv
// rtl/port_grant_tracker_if.sv - request/flit/grant bundle between input channels and one output gate
interface port_grant_tracker_if #(
    parameter int NUM_PORTS = 5,
    parameter int SRC_W     = 4
);
    logic                       enable;
    logic [NUM_PORTS-1:0]       req;
    logic [NUM_PORTS*SRC_W-1:0] req_src;
    logic [NUM_PORTS-1:0]       in_valid;
    logic [NUM_PORTS-1:0]       in_tail;
    logic                       out_ready;
    logic [NUM_PORTS-1:0]       grant;
    logic [SRC_W-1:0]           owner_src;
    logic [NUM_PORTS*SRC_W-1:0] last_src;
    logic                       out_valid;
    logic [NUM_PORTS-1:0]       in_ready;
    logic                       busy;
    logic                       timeout_evt;

    modport master (
        output enable, req, req_src, in_valid, in_tail, out_ready,
        input  grant, owner_src, last_src, out_valid, in_ready, busy, timeout_evt
    );

    modport slave (
        input  enable, req, req_src, in_valid, in_tail, out_ready,
        output grant, owner_src, last_src, out_valid, in_ready, busy, timeout_evt
    );
endinterface

// File: rtl/port_grant_tracker.sv
// rtl/port_grant_tracker.sv - round-robin output-port owner with per-packet lock and idle timeout
module port_grant_tracker #(
    parameter int NUM_PORTS = 5,
    parameter int SRC_W     = 4,
    parameter int TIMEOUT   = 16
) (
    input logic                 clk,
    input logic                 rst,
    port_grant_tracker_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_PORTS);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [SRC_W-1:0] SRC_NONE = '1;

    logic [0:0]                 state;
    logic [PTR_W-1:0]           rr_ptr;
    logic [PTR_W-1:0]           owner;
    logic [CNT_W-1:0]           idle_cnt;
    logic [NUM_PORTS-1:0]       grant_q;
    logic [SRC_W-1:0]           owner_src_q;
    logic [NUM_PORTS*SRC_W-1:0] last_src_q;
    logic                       timeout_evt_q;

    logic                       any_req;
    logic [PTR_W-1:0]           winner;
    logic [SRC_W-1:0]           winner_src;
    logic [PTR_W-1:0]           next_ptr;
    logic [PTR_W:0]             idx;
    logic                       locked;
    logic                       owner_valid;
    logic                       owner_tail;
    logic                       out_valid_w;
    logic                       xfer;
    logic                       expire;

    // First requester at or above rr_ptr, wrapping; idx is one bit wider so rr_ptr+k never overflows.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        idx     = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
            if (idx >= (PTR_W + 1)'(NUM_PORTS)) begin
                idx = idx - (PTR_W + 1)'(NUM_PORTS);
            end
            if (!any_req && bus.req[idx[PTR_W-1:0]]) begin
                any_req = 1'b1;
                winner  = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        winner_src = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (winner == PTR_W'(i)) begin
                winner_src = bus.req_src[i*SRC_W +: SRC_W];
            end
        end
    end

    assign next_ptr    = (owner == PTR_W'(NUM_PORTS - 1)) ? '0 : owner + 1'b1;
    assign locked      = (state == ST_LOCKED);
    assign owner_valid = bus.in_valid[owner];
    assign owner_tail  = bus.in_tail[owner];
    assign out_valid_w = owner_valid & locked & bus.enable;
    assign xfer        = out_valid_w & bus.out_ready;
    assign expire      = (TIMEOUT > 0) && (idle_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            idle_cnt      <= '0;
            grant_q       <= '0;
            owner_src_q   <= SRC_NONE;
            last_src_q    <= '1;
            timeout_evt_q <= 1'b0;
        end else if (bus.enable) begin
            timeout_evt_q <= 1'b0;
            if (state == ST_IDLE) begin
                if (any_req) begin
                    state       <= ST_LOCKED;
                    owner       <= winner;
                    grant_q     <= NUM_PORTS'(1) << winner;
                    owner_src_q <= winner_src;
                    idle_cnt    <= '0;
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (winner == PTR_W'(i)) begin
                            last_src_q[i*SRC_W +: SRC_W] <= winner_src;
                        end
                    end
                end
            end else if (xfer && owner_tail) begin
                state       <= ST_IDLE;
                grant_q     <= '0;
                owner_src_q <= SRC_NONE;
                rr_ptr      <= next_ptr;
            end else if (xfer) begin
                idle_cnt <= '0;
            end else if (expire) begin
                // Forced release behaves like a tail, plus a one-cycle event flag.
                state         <= ST_IDLE;
                grant_q       <= '0;
                owner_src_q   <= SRC_NONE;
                rr_ptr        <= next_ptr;
                timeout_evt_q <= 1'b1;
            end else if (idle_cnt != '1) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    assign bus.grant       = grant_q;
    assign bus.owner_src   = owner_src_q;
    assign bus.last_src    = last_src_q;
    assign bus.out_valid   = out_valid_w;
    assign bus.in_ready    = grant_q & {NUM_PORTS{bus.out_ready & bus.enable}};
    assign bus.busy        = locked;
    assign bus.timeout_evt = timeout_evt_q;
endmodule

// File: tb/tb_port_grant_tracker.sv
// tb/tb_port_grant_tracker.sv - directed and random checks of port_grant_tracker against a packet-level model
module tb_port_grant_tracker;
    localparam int N   = 5;
    localparam int W   = 4;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    port_grant_tracker_if #(.NUM_PORTS(N), .SRC_W(W)) bus ();

    port_grant_tracker #(.NUM_PORTS(N), .SRC_W(W), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: owner index (-1 = gate free), next search start, idle cycles since lock/last flit.
    int           m_owner;
    int           m_ptr;
    int           m_idle;
    bit           m_evt;
    bit           synced = 0;
    logic [W-1:0] m_owner_src;
    logic [W-1:0] m_last [N];
    logic [W-1:0] srcs [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_srcs();
        for (int i = 0; i < N; i++) bus.req_src[i*W +: W] = srcs[i];
    endtask

    task automatic free_gate();
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
    endtask

    task automatic model_step();
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_idle  = 0;
            m_evt   = 0;
            for (int i = 0; i < N; i++) m_last[i] = '1;
            synced = 1;
        end else if (bus.enable) begin
            m_evt = 0;
            if (m_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    int i = (m_ptr + k) % N;
                    if (bus.req[i]) begin
                        m_owner     = i;
                        m_owner_src = srcs[i];
                        m_last[i]   = srcs[i];
                        m_idle      = 0;
                        break;
                    end
                end
            end else begin
                bit moved = bus.in_valid[m_owner] && bus.out_ready;
                if (moved && bus.in_tail[m_owner]) begin
                    free_gate();
                end else if (moved) begin
                    m_idle = 0;
                end else begin
                    m_idle++;
                    if (m_idle == TMO) begin
                        free_gate();
                        m_evt = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_regs();
        logic [N-1:0]   eg;
        logic [N*W-1:0] el;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        for (int i = 0; i < N; i++) el[i*W +: W] = m_last[i];
        chk("grant", 32'(bus.grant), 32'(eg));
        chk("owner_src", 32'(bus.owner_src), 32'((m_owner >= 0) ? m_owner_src : 4'hF));
        chk("busy", 32'(bus.busy), 32'(m_owner >= 0));
        chk("timeout_evt", 32'(bus.timeout_evt), 32'(m_evt));
        chk("last_src", 32'(bus.last_src), 32'(el));
    endtask

    task automatic step();
        logic         ov;
        logic [N-1:0] er;
        #2;
        set_srcs();
        #1;
        if (synced) begin
            ov = (m_owner >= 0) && bus.enable && bus.in_valid[m_owner];
            er = (m_owner >= 0 && bus.enable && bus.out_ready) ? (N'(1) << m_owner) : '0;
            chk("out_valid", 32'(bus.out_valid), 32'(ov));
            chk("in_ready", 32'(bus.in_ready), 32'(er));
        end
        @(posedge clk);
        model_step();
        #1;
        if (synced) check_regs();
    endtask

    task automatic idle_inputs();
        rst = 0; bus.enable = 1; bus.req = '0; bus.in_valid = '0;
        bus.in_tail = '0; bus.out_ready = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) srcs[i] = W'(i + 1);
        idle_inputs();
        set_srcs();

        // 1: reset then a three-flit packet from input 2
        do_reset();
        bus.req = 5'b00100; srcs[2] = 4'h7;
        step();
        chk("t1_grant", 32'(bus.grant), 32'h04);
        chk("t1_owner", 32'(bus.owner_src), 32'h7);
        bus.req = '0; bus.in_valid = 5'b00100;
        step();
        step();
        bus.in_tail = 5'b00100;
        step();
        chk("t1_release", 32'(bus.grant), 32'h0);
        chk("t1_owner_idle", 32'(bus.owner_src), 32'hF);
        idle_inputs();
        bus.req = 5'b11111;
        step();
        chk("t1_next_from_3", 32'(bus.grant), 32'h08);

        // 2: all requesting, single-flit packets
        do_reset();
        bus.req = 5'b11111; bus.in_valid = '1; bus.in_tail = '1;
        for (int c = 0; c < 12; c++) step();

        // 3: owner 1 under backpressure then stall; the frozen counter expires one cycle after resuming
        do_reset();
        bus.req = 5'b00010;
        step();
        bus.req = '0; bus.in_valid = 5'b00010; bus.out_ready = 0;
        for (int c = 0; c < 3; c++) step();
        bus.enable = 0;
        for (int c = 0; c < 2; c++) step();
        chk("t3_hold", 32'(bus.grant), 32'h02);
        bus.enable = 1;
        step();
        chk("t3_evt", 32'(bus.timeout_evt), 32'h1);

        // 4: timeout of owner 3, next search from 4
        idle_inputs();
        bus.req = 5'b01000;
        step();
        bus.req = '0;
        for (int c = 0; c < 4; c++) step();
        chk("t4_evt", 32'(bus.timeout_evt), 32'h1);
        bus.req = 5'b10001;
        step();
        chk("t4_evt_clear", 32'(bus.timeout_evt), 32'h0);
        chk("t4_winner", 32'(bus.grant), 32'h10);

        // 5: tail transfer in the fourth idle cycle
        idle_inputs();
        for (int c = 0; c < 3; c++) step();
        bus.in_valid = 5'b10000; bus.in_tail = 5'b10000;
        step();
        chk("t5_no_evt", 32'(bus.timeout_evt), 32'h0);

        // 6: reset in the middle of a packet
        do_reset();
        srcs[0] = 4'h2;
        bus.req = 5'b00001;
        step();
        bus.in_valid = 5'b00001;
        step();
        rst = 1;
        step();
        rst = 0; bus.req = 5'b00011; bus.in_valid = '0;
        step();
        chk("t6_winner", 32'(bus.grant), 32'h01);

        // Random traffic, including all-ones sources, stalls and occasional resets
        for (int c = 0; c < 600; c++) begin
            rst           = ($urandom_range(0, 99) < 2);
            bus.enable    = ($urandom_range(0, 9) != 0);
            bus.req       = N'($urandom);
            bus.in_valid  = N'($urandom);
            bus.in_tail   = N'($urandom) & N'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) srcs[i] = W'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
